// File: rtl/fp_32_to_int_32.sv
// Converts IEEE-754 single to signed 32-bit integer, round-to-nearest-even, one-bit-per-cycle aligner.
// Latency: 1 edge for special operands, N+3 for normal ones; held in DONE until out_ready.
module fp_32_to_int_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] fp_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] int_out,
  output logic        inexact,
  output logic        invalid
);

  typedef enum logic [1:0] {IDLE, ALIGN, ROUND, DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic        guard_q, guard_d;
  logic        sticky_q, sticky_d;
  logic [4:0]  n_q, n_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic [31:0] int_q, int_d;
  logic        inexact_q, inexact_d;
  logic        invalid_q, invalid_d;

  logic [7:0]  in_exp;
  logic [22:0] in_frac;
  logic        in_nan;
  logic [7:0]  lshift;
  logic [7:0]  rshift;
  logic        inc;
  logic [31:0] rounded;

  assign in_exp  = fp_in[30:23];
  assign in_frac = fp_in[22:0];
  assign in_nan  = (in_exp == 8'd255) && (in_frac != 23'd0);
  // exp >= 150 means unbiased E >= 23 (left shift); otherwise right shift by 150-exp
  assign lshift  = in_exp - 8'd150;
  assign rshift  = 8'd150 - in_exp;
  assign inc     = guard_q & (sticky_q | mag_q[0]);
  assign rounded = mag_q + {31'd0, inc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mag_q     <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
      n_q       <= '0;
      left_q    <= 1'b0;
      sign_q    <= 1'b0;
      int_q     <= '0;
      inexact_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      guard_q   <= guard_d;
      sticky_q  <= sticky_d;
      n_q       <= n_d;
      left_q    <= left_d;
      sign_q    <= sign_d;
      int_q     <= int_d;
      inexact_q <= inexact_d;
      invalid_q <= invalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    guard_d   = guard_q;
    sticky_d  = sticky_q;
    n_d       = n_q;
    left_d    = left_q;
    sign_d    = sign_q;
    int_d     = int_q;
    inexact_d = inexact_q;
    invalid_d = invalid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = fp_in[31];
          mag_d    = {8'd0, (in_exp != 8'd0), in_frac};
          guard_d  = 1'b0;
          sticky_d = 1'b0;
          state_d  = DONE;
          // -2^31 is representable exactly, so it must be caught before the range check
          if (fp_in == 32'hCF00_0000) begin
            int_d     = 32'h8000_0000;
            invalid_d = 1'b0;
            inexact_d = 1'b0;
          end else if ((in_exp == 8'd255) || (in_exp >= 8'd158)) begin
            int_d     = (fp_in[31] && !in_nan) ? 32'h8000_0000 : 32'h7FFF_FFFF;
            invalid_d = 1'b1;
            inexact_d = 1'b0;
          end else if (in_exp == 8'd0) begin
            int_d     = '0;
            invalid_d = 1'b0;
            inexact_d = (in_frac != 23'd0);
          end else begin
            state_d = ALIGN;
            if (in_exp >= 8'd150) begin
              left_d = 1'b1;
              n_d    = lshift[4:0];
            end else begin
              left_d = 1'b0;
              n_d    = (rshift > 8'd25) ? 5'd25 : rshift[4:0];
            end
          end
        end
      end
      ALIGN: begin
        if (n_q != 5'd0) begin
          if (left_q) begin
            mag_d = {mag_q[30:0], 1'b0};
          end else begin
            mag_d    = {1'b0, mag_q[31:1]};
            guard_d  = mag_q[0];
            sticky_d = sticky_q | guard_q;
          end
          n_d = n_q - 5'd1;
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        mag_d     = rounded;
        int_d     = sign_q ? (~rounded + 32'd1) : rounded;
        inexact_d = guard_q | sticky_q;
        invalid_d = 1'b0;
        state_d   = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign int_out   = int_q;
  assign inexact   = inexact_q;
  assign invalid   = invalid_q;

endmodule

// File: tb/tb_fp_32_to_int_32.sv
// Directed bench for fp_32_to_int_32 with hand-computed expected results.
module tb_fp_32_to_int_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] int_out;
  logic        inexact;
  logic        invalid;

  int tests = 0;
  int fails = 0;
  int lat;

  always #5 clk = ~clk;

  fp_32_to_int_32 dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .fp_in(fp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .int_out(int_out), .inexact(inexact), .invalid(invalid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Present operand for the accepting edge, then scramble fp_in and wait for out_valid.
  task automatic launch_and_wait(input logic [31:0] f);
    in_valid = 1'b1;
    fp_in    = f;
    @(posedge clk);
    lat = 1;
    #1;
    in_valid = 1'b0;
    fp_in    = $urandom;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      lat++;
      #1;
    end
  endtask

  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_in_ready_after"}, {31'd0, in_ready}, 32'd1);
  endtask

  task automatic run(input string tag, input logic [31:0] f, input logic [31:0] exp_int,
                     input logic exp_inx, input logic exp_inv, input int exp_lat);
    launch_and_wait(f);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_int"}, int_out, exp_int);
    check({tag, "_inexact"}, {31'd0, inexact}, {31'd0, exp_inx});
    check({tag, "_invalid"}, {31'd0, invalid}, {31'd0, exp_inv});
    if (exp_lat > 0) check({tag, "_latency"}, lat, exp_lat);
    consume(tag);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    fp_in     = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_int", int_out, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_flags", {30'd0, inexact, invalid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    run("one",     32'h3F80_0000, 32'd1,          1'b0, 1'b0, 26);
    run("two_p5",  32'h4020_0000, 32'd2,          1'b1, 1'b0, 25);
    run("m3_p5",   32'hC060_0000, 32'hFFFF_FFFC,  1'b1, 1'b0, 25);
    run("half",    32'h3F00_0000, 32'd0,          1'b1, 1'b0, 27);
    run("max_fin", 32'h4EFF_FFFF, 32'h7FFF_FF80,  1'b0, 1'b0, 10);
    run("min_int", 32'hCF00_0000, 32'h8000_0000,  1'b0, 1'b0, 1);
    run("two31",   32'h4F00_0000, 32'h7FFF_FFFF,  1'b0, 1'b1, 1);
    run("nan",     32'h7FC0_0000, 32'h7FFF_FFFF,  1'b0, 1'b1, 1);
    run("ninf",    32'hFF80_0000, 32'h8000_0000,  1'b0, 1'b1, 1);
    run("denorm",  32'h0000_0001, 32'd0,          1'b1, 1'b0, 1);
    run("m1_p5",   32'hBFC0_0000, 32'hFFFF_FFFE,  1'b1, 1'b0, 26);
    run("big_neg", 32'hCB00_0001, 32'hFF7F_FFFF,  1'b0, 1'b0, 3);

    // Backpressure: result must hold and a new operand must not be taken.
    launch_and_wait(32'h4020_0000);
    in_valid = 1'b1;
    fp_in    = 32'h3F80_0000;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_int", int_out, 32'd2);
      check("hold_inexact", {31'd0, inexact}, 32'd1);
      check("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    consume("hold");
    @(posedge clk);
    #1;
    check("hold_no_new_op", {31'd0, out_valid}, 32'd0);
    check("hold_idle", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of ALIGN discards the operation.
    in_valid = 1'b1;
    fp_in    = 32'h3F80_0000;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_int", int_out, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_flags", {30'd0, inexact, invalid}, 32'd0);
    check("midrst_idle", {31'd0, in_ready}, 32'd1);
    repeat (30) begin
      @(posedge clk);
      #1;
      if (out_valid) break;
    end
    check("midrst_no_output", {31'd0, out_valid}, 32'd0);
    run("ten", 32'h4120_0000, 32'd10, 1'b0, 1'b0, 23);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
